vec_alu_cluster: RTL and testbench
==================================

# vec_alu_cluster

Multi-lane vector integer ALU that runs one whole RVV vector-vector, vector-scalar or vector-immediate arithmetic/logic instruction on VLEN-bit registers. It is the parametrised successor to the per-lane `vec_alu` instances. It owns NB_LANES element lanes internally and handles element scheduling, vl/VLMAX clipping, v0 masking and tail-undisturbed merging. It assembles the complete destination register itself. It sits between the vector register file read/write ports and the core's vector issue logic, using a start/busy/done handshake.

## Interface

Parameters:
- VLEN, 128: vector register width in bits. Power of two, 64..1024.
- NB_LANES, 4: element lanes working in parallel, 1..8. Each lane has a 64-bit (ELEN) datapath.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new instruction. Sampled only in IDLE or DONE.
- opcode  in  6  RVV funct6.
- op_type  in  3  one-hot operand source: 001 VV, 010 VX, 100 VI. Any other value is illegal.
- vsew  in  3  element width: 000 8b, 001 16b, 010 32b, 011 64b. Values >011 are illegal.
- vl  in  $clog2(VLEN/8)+1  requested vector length in elements.
- vm  in  1  RVV vm bit. 0 means masked by v0.
- v0  in  VLEN  mask register.
- vs1, vs2  in  VLEN  source vectors.
- vd_old  in  VLEN  prior destination contents, used for tail and masked-off elements.
- rs1  in  32  scalar operand.
- imm  in  5  immediate operand.
- vd  out  VLEN  result register. Reset value 0.
- busy  out  1  instruction in progress. Reset value 0.
- done  out  1  one-cycle completion pulse. Reset value 0.
- illegal  out  1  valid while done=1: instruction rejected. Reset value 0.

## Operation

- States:
  - IDLE: idle, waiting for start.
  - RUN: processing beats.
  - DONE: done=1 for one cycle.
- On the accepting edge (start=1 while in IDLE or DONE), the block latches every input, loads vd <= vd_old and computes:
  - VLMAX = VLEN >> (vsew+3)
  - evl = min(vl, VLMAX)
  - beats = ceil(evl / NB_LANES)
- Illegal cases go straight to DONE with illegal=1 and vd = vd_old. Illegal means any of:
  - vsew > 011
  - op_type not one-hot
  - opcode unsupported
- If evl = 0, the block goes straight to DONE with illegal=0 and vd = vd_old.
- Otherwise the block enters RUN. On beat b, lane l processes element i = b*NB_LANES + l.
  - Element i occupies bits [i*SEW +: SEW].
  - Lanes with i >= evl are idle. Tail elements keep their vd_old value.
  - If vm=0 and v0[i]=0, the element keeps its vd_old value.
  - Otherwise the element is written with the result of vs2[i] op operand.
- Operand by op_type:
  - VV: vs1[i].
  - VX: rs1 truncated to SEW. For SEW=64 it is sign-extended from 32 bits.
  - VI: imm sign-extended to SEW.
- Supported opcodes:
  - 000000 vadd
  - 000010 vsub (vs2 - op)
  - 000011 vrsub (op - vs2)
  - 000100 vminu
  - 000101 vmin
  - 000110 vmaxu
  - 000111 vmax
  - 001001 vand
  - 001010 vor
  - 001011 vxor
- VI with vsub, vminu, vmin, vmaxu or vmax is illegal.
- Arithmetic rules:
  - All arithmetic is modulo 2^SEW; there is no saturation and no carry between elements.
  - Signed compares use SEW-bit two's complement.
- The block leaves RUN after the last beat and goes to DONE. From DONE it goes to IDLE, or directly to a new RUN if start is accepted.
- vd is stable from done until the next accepted start.

## Timing

- Let the accepting edge be cycle 0.
  - busy=1 from cycle 1 through the last RUN cycle.
  - RUN occupies cycles 1..beats.
  - done=1 in cycle beats+1, with busy=0.
- Illegal or evl=0: done=1 in cycle 1, and busy never rises.
- start while busy=1 is ignored and has no side effects.
- start during DONE is accepted. This allows a back-to-back instruction, which begins RUN in the following cycle.
- Reset at any point, including mid-RUN, forces IDLE with vd=0, busy=0, done=0, illegal=0. The aborted instruction produces no done.
- Input ports only need to be valid on the accepting edge.

## Test plan

- vand 32-bit VV: NB_LANES=4, vl=4, vm=1, vs1=abcdabcdbeefbeef1234567887654321, vs2=8765432112345678beefbeefabcdabcd.
  - Required: vd=83450301122416681224166883450301.
  - done in cycle 2; busy only in cycle 1.
- vadd 8-bit VV: vl=16, NB_LANES=4, same vs1/vs2 as above.
  - Required: 4 beats, done in cycle 5.
  - vd[7:0]=ee, vd[15:8]=ee, vd[127:120]=32.
- Tail and clip, vand 32-bit: vl=3, vd_old all ones.
  - Required: vd=ffffffff122416681224166883450301.
  - Repeat with vl=31: the result equals vl=4 (clipped to VLMAX).
- Masking, vand 32-bit: vm=0, v0=...0101, vd_old=0.
  - Required: vd=00000000122416680000000083450301.
- VX compare, 16-bit, rs1=00000005:
  - vmax: element 0 (vs2=abcd) -> 0005.
  - vmaxu: element 0 -> abcd.
  - VI vmin with same settings: illegal=1 in cycle 1, vd=vd_old.
- Reset and handshake:
  - Assert reset in cycle 2 of a 4-beat run: all outputs 0 next cycle and no done.
  - start while busy: no effect.
  - start on the done cycle: the second result completes after beats+1 more cycles.

Source files
------------

// File: rtl/vec_alu_cluster.sv
// Multi-lane RVV integer ALU: runs one VV/VX/VI instruction over a whole VLEN-bit register,
// NB_LANES elements per beat, with vl clipping, v0 masking and tail-undisturbed merge.
module vec_alu_cluster #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [5:0]                  opcode,
  input  logic [2:0]                  op_type,
  input  logic [2:0]                  vsew,
  input  logic [$clog2(VLEN/8):0]     vl,
  input  logic                        vm,
  input  logic [VLEN-1:0]             v0,
  input  logic [VLEN-1:0]             vs1,
  input  logic [VLEN-1:0]             vs2,
  input  logic [VLEN-1:0]             vd_old,
  input  logic [31:0]                 rs1,
  input  logic [4:0]                  imm,
  output logic [VLEN-1:0]             vd,
  output logic                        busy,
  output logic                        done,
  output logic                        illegal
);
  localparam int VLW = $clog2(VLEN/8) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    sew_mask = 64'h0000_0000_0000_00ff;
      2'd1:    sew_mask = 64'h0000_0000_0000_ffff;
      2'd2:    sew_mask = 64'h0000_0000_ffff_ffff;
      default: sew_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] x, input logic [1:0] sew);
    case (sew)
      2'd0:    sext = {{56{x[7]}}, x[7:0]};
      2'd1:    sext = {{48{x[15]}}, x[15:0]};
      2'd2:    sext = {{32{x[31]}}, x[31:0]};
      default: sext = x;
    endcase
  endfunction

  // Subtract and compare forms have no immediate encoding.
  function automatic logic op_legal(input logic [5:0] op, input logic [2:0] ot);
    logic known, no_vi;
    case (op)
      6'b000000, 6'b000011, 6'b001001, 6'b001010, 6'b001011: begin known = 1'b1; no_vi = 1'b0; end
      6'b000010, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin known = 1'b1; no_vi = 1'b1; end
      default: begin known = 1'b0; no_vi = 1'b0; end
    endcase
    op_legal = known && (ot == 3'b001 || ot == 3'b010 || ot == 3'b100) && !(no_vi && ot == 3'b100);
  endfunction

  // Operands arrive zero-extended to 64 bits; signed compares use the sign-extended copies.
  function automatic logic [63:0] alu_fn(input logic [5:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic [1:0] sew);
    logic [63:0] sa, sb, r;
    sa = sext(a, sew);
    sb = sext(b, sew);
    case (op)
      6'b000000: r = a + b;
      6'b000010: r = a - b;
      6'b000011: r = b - a;
      6'b000100: r = (a < b) ? a : b;
      6'b000101: r = ($signed(sa) < $signed(sb)) ? a : b;
      6'b000110: r = (a > b) ? a : b;
      6'b000111: r = ($signed(sa) > $signed(sb)) ? a : b;
      6'b001001: r = a & b;
      6'b001010: r = a | b;
      6'b001011: r = a ^ b;
      default:   r = 64'd0;
    endcase
    alu_fn = r & sew_mask(sew);
  endfunction

  state_e            state_q, state_d;
  logic [VLEN-1:0]   vd_q, vd_d, v0_q, v0_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d, vm_q, vm_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [2:0]        op_type_q, op_type_d;
  logic [1:0]        vsew_q, vsew_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [4:0]        imm_q, imm_d;
  logic [VLW-1:0]    evl_q, evl_d, beat_q, beat_d;

  logic [VLW-1:0]    vlmax_s, evl_s;
  logic              accept_s, legal_s, last_s, lane_en_s;
  logic [31:0]       idx_s, sh_s;
  logic [VLEN-1:0]   src_a_s, src_b_s, v0_sh_s;
  logic [63:0]       m_s, a_s, b_s, r_s;

  assign vd      = vd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

  // Next-state, operand latching and per-beat lane evaluation.
  always_comb begin
    state_d = state_q;     vd_d = vd_q;         busy_d = busy_q;
    done_d = 1'b0;         illegal_d = 1'b0;    beat_d = beat_q;
    opcode_d = opcode_q;   op_type_d = op_type_q; vsew_d = vsew_q;
    vm_d = vm_q;           v0_d = v0_q;         vs1_d = vs1_q;     vs2_d = vs2_q;
    rs1_d = rs1_q;         imm_d = imm_q;       evl_d = evl_q;
    idx_s = 32'd0;         sh_s = 32'd0;        src_a_s = {VLEN{1'b0}};
    src_b_s = {VLEN{1'b0}}; v0_sh_s = {VLEN{1'b0}}; lane_en_s = 1'b0;
    a_s = 64'd0;           b_s = 64'd0;         r_s = 64'd0;
    m_s = sew_mask(vsew_q);
    case (vsew[1:0])
      2'd0:    vlmax_s = VLW'(VLEN / 8);
      2'd1:    vlmax_s = VLW'(VLEN / 16);
      2'd2:    vlmax_s = VLW'(VLEN / 32);
      default: vlmax_s = VLW'(VLEN / 64);
    endcase
    evl_s    = (vl < vlmax_s) ? vl : vlmax_s;
    legal_s  = op_legal(opcode, op_type) && !vsew[2];
    accept_s = start && (state_q == IDLE || state_q == DONE);
    last_s   = ((32'(beat_q) + 32'd1) * 32'(NB_LANES)) >= 32'(evl_q);
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (accept_s) begin
          vd_d = vd_old;      opcode_d = opcode; op_type_d = op_type; vsew_d = vsew[1:0];
          vm_d = vm;          v0_d = v0;         vs1_d = vs1;         vs2_d = vs2;
          rs1_d = rs1;        imm_d = imm;       evl_d = evl_s;       beat_d = {VLW{1'b0}};
          if (!legal_s) begin
            state_d = DONE;
            done_d = 1'b1;
            illegal_d = 1'b1;
          end else if (evl_s == {VLW{1'b0}}) begin
            state_d = DONE;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int l = 0; l < NB_LANES; l++) begin
          idx_s     = 32'(beat_q) * 32'(NB_LANES) + 32'(l);
          sh_s      = idx_s * (32'd8 << vsew_q);
          v0_sh_s   = v0_q >> idx_s;
          src_a_s   = vs2_q >> sh_s;
          src_b_s   = vs1_q >> sh_s;
          lane_en_s = (idx_s < 32'(evl_q)) && (vm_q || v0_sh_s[0]);
          a_s = src_a_s[63:0] & m_s;
          case (op_type_q)
            3'b001:  b_s = src_b_s[63:0] & m_s;
            3'b010:  b_s = {{32{rs1_q[31]}}, rs1_q} & m_s;
            3'b100:  b_s = {{59{imm_q[4]}}, imm_q} & m_s;
            default: b_s = 64'd0;
          endcase
          r_s = alu_fn(opcode_q, a_s, b_s, vsew_q);
          if (lane_en_s) begin
            vd_d = (vd_d & ~(VLEN'(m_s) << sh_s)) | (VLEN'(r_s) << sh_s);
          end else begin
            vd_d = vd_d;
          end
        end
        if (last_s) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          beat_d = beat_q + VLW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;            vd_q <= {VLEN{1'b0}};  busy_q <= 1'b0;
      done_q <= 1'b0;             illegal_q <= 1'b0;     beat_q <= {VLW{1'b0}};
      opcode_q <= 6'd0;           op_type_q <= 3'd0;     vsew_q <= 2'd0;
      vm_q <= 1'b0;               v0_q <= {VLEN{1'b0}};  vs1_q <= {VLEN{1'b0}};
      vs2_q <= {VLEN{1'b0}};      rs1_q <= 32'd0;        imm_q <= 5'd0;
      evl_q <= {VLW{1'b0}};
    end else begin
      state_q <= state_d;         vd_q <= vd_d;          busy_q <= busy_d;
      done_q <= done_d;           illegal_q <= illegal_d; beat_q <= beat_d;
      opcode_q <= opcode_d;       op_type_q <= op_type_d; vsew_q <= vsew_d;
      vm_q <= vm_d;               v0_q <= v0_d;          vs1_q <= vs1_d;
      vs2_q <= vs2_d;             rs1_q <= rs1_d;        imm_q <= imm_d;
      evl_q <= evl_d;
    end
  end
endmodule

// File: tb/tb_vec_alu_cluster.sv
// Self-checking bench for vec_alu_cluster (VLEN=128, NB_LANES=4): directed cases plus
// randomized instructions against an element-level reference model.
module tb_vec_alu_cluster;
  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         reset, start, vm;
  logic [5:0]   opcode;
  logic [2:0]   op_type, vsew;
  logic [4:0]   vl;
  logic [127:0] v0, vs1, vs2, vd_old, vd;
  logic [31:0]  rs1;
  logic [4:0]   imm;
  logic         busy, done, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VS1_C = 128'habcdabcd_beefbeef_12345678_87654321;
  localparam logic [127:0] VS2_C = 128'h87654321_12345678_beefbeef_abcdabcd;

  vec_alu_cluster #(.VLEN(128), .NB_LANES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op_type(op_type),
    .vsew(vsew), .vl(vl), .vm(vm), .v0(v0), .vs1(vs1), .vs2(vs2), .vd_old(vd_old),
    .rs1(rs1), .imm(imm), .vd(vd), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference: walks elements of the current inputs using plain SEW arithmetic.
  task automatic model(output logic [127:0] exp_vd, output logic exp_ill, output int exp_beats);
    int sewb, vlmax, evl;
    logic [63:0] m, a, b, r, sb;
    logic legal;
    exp_vd = vd_old; exp_ill = 1'b0; exp_beats = 0;
    legal = (vsew <= 3'd3) && (op_type inside {3'b001, 3'b010, 3'b100})
            && (opcode inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11})
            && !(op_type == 3'b100 && (opcode inside {6'd2, 6'd4, 6'd5, 6'd6, 6'd7}));
    if (!legal) begin
      exp_ill = 1'b1;
      return;
    end
    sewb = 8 << vsew;
    vlmax = 128 / sewb;
    evl = (int'(vl) < vlmax) ? int'(vl) : vlmax;
    exp_beats = (evl + NB - 1) / NB;
    m  = (sewb == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << sewb) - 64'd1);
    sb = 64'd1 << (sewb - 1);
    for (int i = 0; i < evl; i++) begin
      if (!vm && !v0[i]) continue;
      a = 64'(vs2 >> (i * sewb)) & m;
      case (op_type)
        3'b001:  b = 64'(vs1 >> (i * sewb)) & m;
        3'b010:  b = {{32{rs1[31]}}, rs1} & m;
        default: b = {{59{imm[4]}}, imm} & m;
      endcase
      case (opcode)
        6'd0:    r = a + b;
        6'd2:    r = a - b;
        6'd3:    r = b - a;
        6'd4:    r = (a < b) ? a : b;
        6'd5:    r = ((a ^ sb) < (b ^ sb)) ? a : b;
        6'd6:    r = (a > b) ? a : b;
        6'd7:    r = ((a ^ sb) > (b ^ sb)) ? a : b;
        6'd9:    r = a & b;
        6'd10:   r = a | b;
        default: r = a ^ b;
      endcase
      r = r & m;
      for (int k = 0; k < sewb; k++) exp_vd[i * sewb + k] = r[k];
    end
  endtask

  // Pulses start, then waits (bounded) for done; cycle 1 is the first cycle after acceptance.
  task automatic do_instr(output int done_cyc, output int busy_cnt, output logic busy_at_done);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; busy_cnt = 0; busy_at_done = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic set_vand32(input logic [4:0] len);
    opcode = 6'd9; op_type = 3'b001; vsew = 3'd2; vl = len; vm = 1'b1;
    v0 = 128'd0; vs1 = VS1_C; vs2 = VS2_C; vd_old = 128'd0; rs1 = 32'd0; imm = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    set_vand32(5'd4);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({vd, busy, done, illegal} !== 131'd0) begin
      errors++;
      $display("FAIL reset_state: vd=%h busy=%b done=%b illegal=%b, required all 0", vd, busy, done, illegal);
    end
  endtask

  task automatic test_vand32();
    int dc, bc; logic bd;
    set_vand32(5'd4);
    do_instr(dc, bc, bd);
    checks += 4;
    if (vd !== 128'h83450301_12241668_12241668_83450301) begin
      errors++; $display("FAIL vand32_vd: got %h required 83450301122416681224166883450301", vd);
    end
    if (dc !== 2) begin errors++; $display("FAIL vand32_done_cycle: got %0d required 2", dc); end
    if (bc !== 1 || bd !== 1'b0) begin
      errors++; $display("FAIL vand32_busy: busy cycles %0d busy_at_done %b, required 1 and 0", bc, bd);
    end
    if (illegal !== 1'b0) begin errors++; $display("FAIL vand32_illegal: got %b required 0", illegal); end
  endtask

  task automatic test_vadd8();
    int dc, bc; logic bd;
    set_vand32(5'd16);
    opcode = 6'd0; vsew = 3'd0;
    do_instr(dc, bc, bd);
    checks += 3;
    if (dc !== 5 || bc !== 4) begin
      errors++; $display("FAIL vadd8_timing: done cycle %0d busy cycles %0d, required 5 and 4", dc, bc);
    end
    if (vd[7:0] !== 8'hee || vd[15:8] !== 8'hee) begin
      errors++; $display("FAIL vadd8_low: got %h required eeee", vd[15:0]);
    end
    if (vd[127:120] !== 8'h32) begin
      errors++; $display("FAIL vadd8_top: got %h required 32", vd[127:120]);
    end
  endtask

  task automatic test_tail_clip();
    int dc, bc; logic bd;
    set_vand32(5'd3);
    vd_old = {128{1'b1}};
    do_instr(dc, bc, bd);
    checks++;
    if (vd !== 128'hffffffff_12241668_12241668_83450301) begin
      errors++; $display("FAIL tail_vl3: got %h required ffffffff122416681224166883450301", vd);
    end
    vl = 5'd31;
    do_instr(dc, bc, bd);
    checks++;
    if (vd !== 128'h83450301_12241668_12241668_83450301 || dc !== 2) begin
      errors++; $display("FAIL clip_vl31: got %h cycle %0d required 83450301122416681224166883450301 cycle 2", vd, dc);
    end
  endtask

  task automatic test_mask();
    int dc, bc; logic bd;
    set_vand32(5'd4);
    vm = 1'b0; v0 = 128'h5;
    do_instr(dc, bc, bd);
    checks++;
    if (vd !== 128'h00000000_12241668_00000000_83450301) begin
      errors++; $display("FAIL mask_vd: got %h required 00000000122416680000000083450301", vd);
    end
  endtask

  task automatic test_vx_compare();
    int dc, bc; logic bd;
    set_vand32(5'd8);
    vsew = 3'd1; op_type = 3'b010; rs1 = 32'h00000005; opcode = 6'd7;
    do_instr(dc, bc, bd);
    checks++;
    if (vd[15:0] !== 16'h0005) begin errors++; $display("FAIL vmax_vx: got %h required 0005", vd[15:0]); end
    opcode = 6'd6;
    do_instr(dc, bc, bd);
    checks++;
    if (vd[15:0] !== 16'habcd) begin errors++; $display("FAIL vmaxu_vx: got %h required abcd", vd[15:0]); end
    opcode = 6'd5; op_type = 3'b100; imm = 5'd5; vd_old = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    do_instr(dc, bc, bd);
    checks++;
    if (illegal !== 1'b1 || dc !== 1 || bc !== 0 || vd !== 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321) begin
      errors++;
      $display("FAIL vi_vmin_illegal: illegal=%b cycle=%0d busy cycles=%0d vd=%h, required 1, 1, 0, vd_old", illegal, dc, bc, vd);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};
    logic [2:0] ots [3] = '{3'b001, 3'b010, 3'b100};
    logic [127:0] ev; logic ei; int eb, dc, bc; logic bd;
    for (int n = 0; n < 60; n++) begin
      opcode  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      op_type = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ots[$urandom_range(0, 2)];
      vsew    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      vl = 5'($urandom_range(0, 31)); vm = 1'($urandom);
      v0     = {$urandom, $urandom, $urandom, $urandom};
      vs1    = {$urandom, $urandom, $urandom, $urandom};
      vs2    = {$urandom, $urandom, $urandom, $urandom};
      vd_old = {$urandom, $urandom, $urandom, $urandom};
      rs1 = $urandom; imm = 5'($urandom);
      model(ev, ei, eb);
      do_instr(dc, bc, bd);
      checks++;
      if (vd !== ev || illegal !== ei || dc !== eb + 1 || bc !== eb || bd !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: op=%h type=%b sew=%0d vl=%0d vd=%h ill=%b cyc=%0d busy=%0d, required vd=%h ill=%b cyc=%0d busy=%0d",
                 n, opcode, op_type, vsew, vl, vd, illegal, dc, bc, ev, ei, eb + 1, eb);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    set_vand32(5'd16);
    opcode = 6'd0; vsew = 3'd0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({vd, busy, done, illegal} !== 131'd0) begin
      errors++; $display("FAIL reset_mid_run: vd=%h busy=%b done=%b illegal=%b, required all 0", vd, busy, done, illegal);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_done: %0d active cycles after abort, required 0", seen); end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] ev; logic ei; int eb, dc = -1;
    set_vand32(5'd16);
    opcode = 6'd0; vsew = 3'd0;
    model(ev, ei, eb);
    start = 1'b1;
    @(posedge clk); #1;
    opcode = 6'd11; vl = 5'd2; vs2 = {$urandom, $urandom, $urandom, $urandom}; vd_old = 128'd7;
    for (int c = 1; c <= 100; c++) begin
      if (c == 3) start = 1'b0;
      if (done) begin dc = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (dc !== eb + 1 || vd !== ev) begin
      errors++; $display("FAIL start_while_busy: cycle %0d vd=%h, required cycle %0d vd=%h", dc, vd, eb + 1, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ev; logic ei; int eb, dc, bc; logic bd;
    set_vand32(5'd4);
    model(ev, ei, eb);
    do_instr(dc, bc, bd);
    checks++;
    if (dc !== 2 || vd !== ev) begin
      errors++; $display("FAIL b2b_first: cycle %0d vd=%h, required cycle 2 vd=%h", dc, vd, ev);
    end
    opcode = 6'd3; vsew = 3'd0; vl = 5'd16;
    vs1 = {$urandom, $urandom, $urandom, $urandom}; vs2 = {$urandom, $urandom, $urandom, $urandom};
    model(ev, ei, eb);
    do_instr(dc, bc, bd);
    checks++;
    if (dc !== 5 || bc !== 4 || vd !== ev) begin
      errors++; $display("FAIL b2b_second: cycle %0d busy %0d vd=%h, required cycle 5 busy 4 vd=%h", dc, bc, vd, ev);
    end
  endtask

  initial begin
    test_reset();
    test_vand32();
    test_vadd8();
    test_tail_clip();
    test_mask();
    test_vx_compare();
    test_random();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
